// File: rtl/dsp_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_stream_pkg
// Purpose  : Shared DAC code constants, slot kinds and the scale/saturate
//            helpers for the DAC transmit stream.
// Revision : 1.0 - initial release
// ============================================================================
package dsp_stream_pkg;

    localparam int DAC_CODE_W = 14;

    // Offset-binary DAC codes
    localparam logic [DAC_CODE_W-1:0] DAC_MIDSCALE = 14'h2000;
    localparam logic [DAC_CODE_W-1:0] DAC_MAX      = 14'h3FFF;
    localparam logic [DAC_CODE_W-1:0] DAC_MIN      = 14'h0000;

    // Two's complement range representable by the DAC
    localparam logic signed [63:0] SAT_HI = 64'sd8191;
    localparam logic signed [63:0] SAT_LO = -64'sd8192;

    // What a pipeline slot will write when it reaches the DAC pins
    typedef enum logic [1:0] {
        SLOT_SAMPLE   = 2'd0,
        SLOT_HOLD     = 2'd1,
        SLOT_MIDSCALE = 2'd2
    } slot_kind_e;

    // Offset binary is two's complement with the MSB inverted, which is the
    // same as XOR with the midscale code; the same XOR maps back.
    function automatic logic [DAC_CODE_W-1:0] to_offset_binary(
        input logic signed [DAC_CODE_W-1:0] sat
    );
        return sat ^ DAC_MIDSCALE;
    endfunction

    // Arithmetic right shift (floor) followed by clamping to the DAC range
    function automatic logic signed [DAC_CODE_W-1:0] sat_shift(
        input logic signed [63:0] sample,
        input logic [5:0]         shamt
    );
        logic signed [63:0] shifted;
        shifted = sample >>> shamt;
        if (shifted > SAT_HI) begin
            return DAC_MAX ^ DAC_MIDSCALE;
        end else if (shifted < SAT_LO) begin
            return DAC_MIN ^ DAC_MIDSCALE;
        end
        return shifted[DAC_CODE_W-1:0];
    endfunction

    // Full sample-to-code conversion in one step
    function automatic logic [DAC_CODE_W-1:0] sat_to_dac(
        input logic signed [63:0] sample,
        input logic [5:0]         shamt
    );
        return to_offset_binary(sat_shift(sample, shamt));
    endfunction

endpackage : dsp_stream_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock first-word-fall-through FIFO with occupancy output
//            and synchronous flush. DEPTH must be a power of two.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int C_AW    = $clog2(DEPTH);
    localparam int C_LVL_W = C_AW + 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [C_AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [C_AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [C_LVL_W-1:0] level_q,  level_d;
    logic               w_wr;
    logic               w_rd;

    assign empty   = (level_q == '0);
    assign full    = (level_q == C_LVL_W'(DEPTH));
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Flush wins over any same-cycle push or pop
    assign w_wr = push && !full  && !flush;
    assign w_rd = pop  && !empty && !flush;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_rd) rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + C_LVL_W'(w_wr) - C_LVL_W'(w_rd);
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Sample storage; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/dac_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : dac_stream_tx
// Purpose  : Buffers signed processed samples, drains them at a programmable
//            rate, scales/saturates to 14-bit offset binary and drives the
//            DAC data and write strobe. Counts underflows and refused beats.
// Revision : 1.0 - initial release
// ============================================================================
module dac_stream_tx
    import dsp_stream_pkg::*;
#(
    parameter int IN_W       = 64,
    parameter int DAC_W      = 14,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          flush,
    input  logic [15:0]                   rate_div,
    input  logic [5:0]                    shift,
    input  logic [IN_W-1:0]               data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic [DAC_W-1:0]              dac_data,
    output logic                          dac_wrt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              underflow_count,
    output logic [CNT_W-1:0]              drop_count
);

    localparam int C_LVL_W = $clog2(FIFO_DEPTH) + 1;

    // Combinational nets
    logic                        w_run;
    logic                        w_tick;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_empty;
    logic                        w_full;
    logic                        w_drop_evt;
    logic                        w_under_evt;
    logic [15:0]                 w_period;
    logic [IN_W-1:0]             w_head;
    logic signed [63:0]          w_head_ext;
    logic [C_LVL_W-1:0]          w_level;

    // Registered state
    logic [15:0]                 tick_cnt_q,  tick_cnt_d;
    logic [15:0]                 period_q,    period_d;
    logic                        primed_q,    primed_d;
    logic [CNT_W-1:0]            under_cnt_q, under_cnt_d;
    logic [CNT_W-1:0]            drop_cnt_q,  drop_cnt_d;
    logic                        s1_valid_q,  s1_valid_d;
    slot_kind_e                  s1_kind_q,   s1_kind_d;
    logic signed [DAC_CODE_W-1:0] s1_sat_q,   s1_sat_d;
    logic [DAC_W-1:0]            dac_data_q,  dac_data_d;
    logic                        dac_wrt_q,   dac_wrt_d;

    sync_fifo #(
        .WIDTH (IN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (w_push),
        .wr_data (data_in),
        .pop     (w_pop),
        .rd_data (w_head),
        .empty   (w_empty),
        .full    (w_full),
        .level   (w_level)
    );

    assign w_run         = enable && !flush;
    assign data_in_ready = w_run && !w_full;
    assign w_push        = data_in_valid && data_in_ready;
    assign w_pop         = w_tick && !w_empty;
    assign w_drop_evt    = enable && data_in_valid && !data_in_ready;
    assign w_under_evt   = w_tick && w_empty && primed_q;
    assign w_head_ext    = 64'(signed'(w_head));

    assign dac_data        = dac_data_q;
    assign dac_wrt         = dac_wrt_q;
    assign fifo_level      = w_level;
    assign underflow_count = under_cnt_q;
    assign drop_count      = drop_cnt_q;

    // Tick generator; the period is sampled at count 0 so a rate_div change
    // only affects the period that starts after the next wrap
    always_comb begin
        w_period   = (tick_cnt_q == '0) ? rate_div : period_q;
        w_tick     = w_run && (tick_cnt_q == w_period);
        period_d   = w_period;
        tick_cnt_d = '0;
        if (w_run && !w_tick) begin
            tick_cnt_d = tick_cnt_q + 16'd1;
        end
    end

    // Primed flag and saturating diagnostic counters
    always_comb begin
        primed_d    = primed_q;
        under_cnt_d = under_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (flush) begin
            primed_d = 1'b0;
        end else if (w_pop) begin
            primed_d = 1'b1;
        end
        if (w_under_evt && !(&under_cnt_q)) begin
            under_cnt_d = under_cnt_q + 1'b1;
        end
        if (w_drop_evt && !(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Stage 1: every tick launches a slot; popped samples are shifted and
    // saturated here, starved slots only record what to re-emit
    always_comb begin
        s1_valid_d = w_tick;
        s1_kind_d  = s1_kind_q;
        s1_sat_d   = s1_sat_q;
        if (w_tick) begin
            if (!w_empty) begin
                s1_kind_d = SLOT_SAMPLE;
                s1_sat_d  = sat_shift(w_head_ext, shift);
            end else if (primed_q) begin
                s1_kind_d = SLOT_HOLD;
            end else begin
                s1_kind_d = SLOT_MIDSCALE;
            end
        end
    end

    // Stage 2: update the DAC pins and strobe once per launched slot
    always_comb begin
        dac_wrt_d  = s1_valid_q;
        dac_data_d = dac_data_q;
        if (s1_valid_q) begin
            case (s1_kind_q)
                SLOT_SAMPLE:   dac_data_d = to_offset_binary(s1_sat_q);
                SLOT_MIDSCALE: dac_data_d = DAC_MIDSCALE;
                default:       dac_data_d = dac_data_q;
            endcase
        end
    end

    // State registers; reset returns the DAC to midscale immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q  <= '0;
            period_q    <= '0;
            primed_q    <= 1'b0;
            under_cnt_q <= '0;
            drop_cnt_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_kind_q   <= SLOT_HOLD;
            s1_sat_q    <= '0;
            dac_data_q  <= DAC_MIDSCALE;
            dac_wrt_q   <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            period_q    <= period_d;
            primed_q    <= primed_d;
            under_cnt_q <= under_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_kind_q   <= s1_kind_d;
            s1_sat_q    <= s1_sat_d;
            dac_data_q  <= dac_data_d;
            dac_wrt_q   <= dac_wrt_d;
        end
    end

endmodule : dac_stream_tx
`default_nettype wire
